incdec_stepper: RTL and testbench

Multi-cycle sequential counterpart of our combinational assignment-expression datapath: it executes the same fixed program of pre/post-increment, pre/post-decrement and nested-assignment steps on three working registers, one step per clock. A result is published only when the whole program has completed. The block sits behind a valid/ready request port and returns results with a one-cycle done pulse. Per-step debug outputs let benches compare every intermediate value with the combinational reference model.

---
 rtl/incdec_stepper.sv | 148 ++++++++++++++
 tb/tb_incdec_stepper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/incdec_stepper.sv
// incdec_stepper
// Runs a fixed program of increment, decrement and nested-assignment steps on
// three working registers x, y and z, one step per clock. Results are
// published only after the whole program has completed.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request valid; accepted when start && ready
//   a         operand, sampled on the accepting edge
//   ready     high in IDLE and in the DONE cycle
//   busy      high while the program runs (RUN)
//   done      one-cycle pulse; ox/oy/oz are valid from this cycle on
//   ox,oy,oz  final results, held until the next completion
//   dbg_step  index of the last executed step (0 = load)
//   dbg_x/y/z working registers (post-step values)
module incdec_stepper #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ox,
  output logic [WIDTH-1:0] oy,
  output logic [WIDTH-1:0] oz,
  output logic [3:0]       dbg_step,
  output logic [WIDTH-1:0] dbg_x,
  output logic [WIDTH-1:0] dbg_y,
  output logic [WIDTH-1:0] dbg_z
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] K99 = WIDTH'(99);
  localparam logic [3:0]       LAST_BEFORE_FINAL = 4'd10;

  state_t           state, state_nx;
  logic [WIDTH-1:0] x, y, z;
  logic [WIDTH-1:0] x_nx, y_nx, z_nx;
  logic [3:0]       step_nx;
  logic             accept;
  logic             last_step;

  // Modulo-2^WIDTH increment/decrement; carries and borrows are discarded.
  function automatic logic [WIDTH-1:0] inc(input logic [WIDTH-1:0] v);
    return v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] v);
    return v - ONE;
  endfunction

  assign ready     = (state == IDLE) || (state == DONE);
  assign busy      = (state == RUN);
  assign accept    = start && ready;
  assign step_nx   = dbg_step + 4'd1;
  // The edge executing step 11 also leaves RUN.
  assign last_step = (dbg_step == LAST_BEFORE_FINAL);

  assign dbg_x = x;
  assign dbg_y = y;
  assign dbg_z = z;

  // Result of executing step dbg_step+1 on the current working registers.
  always_comb begin
    x_nx = x;
    y_nx = y;
    z_nx = z;
    case (step_nx)
      4'd1:  x_nx = inc(x);
      4'd2:  z_nx = dec(z);
      4'd3:  z_nx = inc(z);
      4'd4:  x_nx = dec(x);
      4'd5:  begin
               x_nx = inc(x);
               z_nx = inc(x);
             end
      4'd6:  begin
               x_nx = dec(x);
               y_nx = dec(x);
             end
      4'd7:  z_nx = K99;
      4'd8:  y_nx = inc(z);
      4'd9:  x_nx = inc(y);
      4'd10: y_nx = '0;
      4'd11: z_nx = y;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Working registers, step counter and published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      dbg_step <= '0;
      ox       <= '0;
      oy       <= '0;
      oz       <= '0;
      done     <= 1'b0;
    end else begin
      // done trails the DONE state by one cycle so a request accepted in the
      // DONE cycle keeps a 12-cycle request-to-done latency and period.
      done <= (state == DONE);
      if (state == RUN) begin
        x        <= x_nx;
        y        <= y_nx;
        z        <= z_nx;
        dbg_step <= step_nx;
        if (last_step) begin
          ox <= x_nx;
          oy <= y_nx;
          oz <= z_nx;
        end
      end else if (accept) begin
        x        <= a;
        y        <= '0;
        z        <= '0;
        dbg_step <= '0;
      end
    end
  end

endmodule

// File: tb/tb_incdec_stepper.sv
module tb_incdec_stepper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic        ready, busy, done;
  logic [31:0] ox, oy, oz, dbg_x, dbg_y, dbg_z;
  logic [3:0]  dbg_step;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  bit cmp_en  = 1'b0;

  incdec_stepper #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a),
    .ready(ready), .busy(busy), .done(done),
    .ox(ox), .oy(oy), .oz(oz),
    .dbg_step(dbg_step), .dbg_x(dbg_x), .dbg_y(dbg_y), .dbg_z(dbg_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Register values {x,y,z} after step k of the program for operand v,
  // written out directly from the program description.
  function automatic logic [95:0] trace(input logic [31:0] v, input int k);
    logic [31:0] p1, m1;
    p1 = v + 32'd1;
    m1 = 32'hFFFF_FFFF;
    case (k)
      0:  return {v,      32'd0,   32'd0};
      1:  return {p1,     32'd0,   32'd0};
      2:  return {p1,     32'd0,   m1};
      3:  return {p1,     32'd0,   32'd0};
      4:  return {v,      32'd0,   32'd0};
      5:  return {p1,     32'd0,   p1};
      6:  return {v,      v,       p1};
      7:  return {v,      v,       32'd99};
      8:  return {v,      32'd100, 32'd99};
      9:  return {32'd101, 32'd100, 32'd99};
      10: return {32'd101, 32'd0,  32'd99};
      default: return {32'd101, 32'd0, 32'd0};
    endcase
  endfunction

  // Model: m_k = -1 idle, 0..10 running with that many steps done, 12 = DONE cycle.
  int          m_k, m_step;
  logic [31:0] m_a, m_ox, m_oy, m_oz;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= -1; m_step <= 0; m_a <= '0;
      m_ox <= '0; m_oy <= '0; m_oz <= '0; m_done <= 1'b0;
    end else begin
      m_done <= (m_k == 12);
      if (m_k >= 0 && m_k <= 9) begin
        m_k <= m_k + 1;
        m_step <= m_k + 1;
      end else if (m_k == 10) begin
        m_k <= 12;
        m_step <= 11;
        {m_ox, m_oy, m_oz} <= trace(m_a, 11);
      end else if (start && (m_k == -1 || m_k == 12)) begin
        m_k <= 0;
        m_step <= 0;
        m_a <= a;
      end else if (m_k == 12) begin
        m_k <= -1;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [95:0] t;
    forever begin
      @(posedge clk);
      #2;
      if (done === 1'b1) n_done++;
      if (cmp_en) begin
        t = trace(m_a, m_step);
        chk("ready", 32'(ready), 32'(m_k == -1 || m_k == 12));
        chk("busy",  32'(busy),  32'(m_k >= 0 && m_k <= 10));
        chk("done",  32'(done),  32'(m_done));
        chk("ox", ox, m_ox);
        chk("oy", oy, m_oy);
        chk("oz", oz, m_oz);
        chk("dbg_step", 32'(dbg_step), 32'(m_step));
        chk("dbg_x", dbg_x, t[95:64]);
        chk("dbg_y", dbg_y, t[63:32]);
        chk("dbg_z", dbg_z, t[31:0]);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] lx [12];
    int d0;
    lx = '{32'd5, 32'd6, 32'd6, 32'd6, 32'd5, 32'd6, 32'd5, 32'd5, 32'd5, 32'd101, 32'd101, 32'd101};

    // Reset state
    idle(3);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_ox",    ox,         32'd0);
    chk("rst_step",  32'(dbg_step), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(2);

    // a = 5 with hand-computed trace
    a = 32'd5; start = 1'b1;
    d0 = n_done;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #3;
      start = 1'b0;
      if (k <= 11) begin
        chk("a5_step", 32'(dbg_step), 32'(k));
        chk("a5_x", dbg_x, lx[k]);
        chk("a5_ready", 32'(ready), 32'(k == 11));
        chk("a5_nodone", 32'(done), 32'd0);
      end
      if (k == 2) chk("a5_z2", dbg_z, 32'hFFFF_FFFF);
      if (k == 3) chk("a5_z3", dbg_z, 32'd0);
      if (k == 5) chk("a5_z5", dbg_z, 32'd6);
      if (k == 6) chk("a5_y6", dbg_y, 32'd5);
      if (k == 7) chk("a5_z7", dbg_z, 32'd99);
      if (k == 8) chk("a5_y8", dbg_y, 32'd100);
      if (k == 12) begin
        chk("a5_done", 32'(done), 32'd1);
        chk("a5_ox", ox, 32'd101);
        chk("a5_oy", oy, 32'd0);
        chk("a5_oz", oz, 32'd0);
      end
    end
    // Idle 20 cycles: results hold, no more done
    idle(20);
    chk("hold_ox", ox, 32'd101);
    chk("hold_ndone", 32'(n_done - d0), 32'd1);

    // a = all ones: wrap cases
    @(negedge clk);
    a = 32'hFFFF_FFFF; start = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #3;
      start = 1'b0;
      if (k == 1) chk("wrap_x1", dbg_x, 32'd0);
      if (k == 5) begin
        chk("wrap_x5", dbg_x, 32'd0);
        chk("wrap_z5", dbg_z, 32'd0);
      end
      if (k == 6) begin
        chk("wrap_x6", dbg_x, 32'hFFFF_FFFF);
        chk("wrap_y6", dbg_y, 32'hFFFF_FFFF);
      end
      if (k == 12) chk("wrap_ox", ox, 32'd101);
    end
    idle(3);

    // start pulses during RUN are ignored
    d0 = n_done;
    @(negedge clk); a = 32'd77; start = 1'b1;
    @(negedge clk); start = 1'b0;
    idle(2); start = 1'b1; a = 32'd1;
    @(negedge clk); start = 1'b0;
    idle(3); start = 1'b1; a = 32'd2;
    @(negedge clk); start = 1'b0;
    idle(15);
    chk("pulse_ndone", 32'(n_done - d0), 32'd1);

    // start held high: done every 12 cycles
    d0 = n_done;
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a = $urandom;
    end
    start = 1'b0;
    idle(1);
    chk("held_ndone", 32'(n_done - d0), 32'd5);
    idle(15);

    // Reset asserted at step 6 aborts the run
    d0 = n_done;
    @(negedge clk); a = 32'd9; start = 1'b1;
    @(posedge clk); #3; start = 1'b0;
    for (int i = 0; i < 6; i++) @(posedge clk);
    #3;
    chk("abort_step", 32'(dbg_step), 32'd6);
    @(negedge clk); rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(15);
    chk("abort_ndone", 32'(n_done - d0), 32'd0);
    chk("abort_ox", ox, 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = $urandom;
    end
    start = 1'b0;
    idle(15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
